// File: rtl/ct_had_tap_pkg.sv
// Shared TAP state encodings, HAD register indices and expected DR lengths
// for the HAD JTAG sequencer.
package ct_had_tap_pkg;

   typedef enum logic [3:0] {
      TAP_EX2_DR = 4'h0,
      TAP_EX1_DR = 4'h1,
      TAP_SH_DR  = 4'h2,
      TAP_PAU_DR = 4'h3,
      TAP_SEL_IR = 4'h4,
      TAP_UPD_DR = 4'h5,
      TAP_CAP_DR = 4'h6,
      TAP_SEL_DR = 4'h7,
      TAP_EX2_IR = 4'h8,
      TAP_EX1_IR = 4'h9,
      TAP_SH_IR  = 4'hA,
      TAP_PAU_IR = 4'hB,
      TAP_RTI    = 4'hC,
      TAP_UPD_IR = 4'hD,
      TAP_CAP_IR = 4'hE,
      TAP_TLR    = 4'hF
   } tap_state_e;

   localparam logic [7:0] IR_RST_VAL = 8'hFF;
   localparam int         NUM_SEL    = 16;

   localparam logic [4:0] IDX_OTC      = 5'h01;
   localparam logic [4:0] IDX_MBCA     = 5'h02;
   localparam logic [4:0] IDX_MBCB     = 5'h03;
   localparam logic [4:0] IDX_BAMA     = 5'h04;
   localparam logic [4:0] IDX_BAMB     = 5'h05;
   localparam logic [4:0] IDX_CSR      = 5'h06;
   localparam logic [4:0] IDX_WBBR     = 5'h08;
   localparam logic [4:0] IDX_PC       = 5'h09;
   localparam logic [4:0] IDX_PCFIFO   = 5'h0A;
   localparam logic [4:0] IDX_PIPEFIFO = 5'h0B;
   localparam logic [4:0] IDX_BABA     = 5'h0C;
   localparam logic [4:0] IDX_BABB     = 5'h0D;
   localparam logic [4:0] IDX_DADDR    = 5'h0E;
   localparam logic [4:0] IDX_DDATA    = 5'h0F;
   localparam logic [4:0] IDX_DBGFIFO  = 5'h10;
   localparam logic [4:0] IDX_DBGFIFO2 = 5'h11;

   // Bit positions of the one-hot select vector
   localparam int SEL_OTC      = 0;
   localparam int SEL_MBCA     = 1;
   localparam int SEL_MBCB     = 2;
   localparam int SEL_BAMA     = 3;
   localparam int SEL_BAMB     = 4;
   localparam int SEL_CSR      = 5;
   localparam int SEL_WBBR     = 6;
   localparam int SEL_PC       = 7;
   localparam int SEL_PCFIFO   = 8;
   localparam int SEL_PIPEFIFO = 9;
   localparam int SEL_BABA     = 10;
   localparam int SEL_BABB     = 11;
   localparam int SEL_DADDR    = 12;
   localparam int SEL_DDATA    = 13;
   localparam int SEL_DBGFIFO  = 14;
   localparam int SEL_DBGFIFO2 = 15;

   localparam logic [6:0] LEN_8         = 7'd8;
   localparam logic [6:0] LEN_16        = 7'd16;
   localparam logic [6:0] LEN_32        = 7'd32;
   localparam logic [6:0] LEN_64        = 7'd64;
   localparam logic [6:0] SHIFT_CNT_MAX = 7'd127;

endpackage

// File: rtl/ct_had_tap_seq_ir_decode.sv
// Combinational IR index decode: one-hot HAD register selects and the
// DR length the selected register expects (32 when nothing is selected).
module ct_had_ir_decode
   import ct_had_tap_pkg::*;
(
   input  logic [4:0]         ir_idx,
   output logic [NUM_SEL-1:0] reg_sel,
   output logic [6:0]         exp_len
);

   always_comb begin
      reg_sel = '0;
      exp_len = LEN_32;
      case (ir_idx)
         IDX_OTC:      begin reg_sel[SEL_OTC]      = 1'b1; exp_len = LEN_8;  end
         IDX_MBCA:     begin reg_sel[SEL_MBCA]     = 1'b1; exp_len = LEN_8;  end
         IDX_MBCB:     begin reg_sel[SEL_MBCB]     = 1'b1; exp_len = LEN_8;  end
         IDX_BAMA:     begin reg_sel[SEL_BAMA]     = 1'b1; exp_len = LEN_8;  end
         IDX_BAMB:     begin reg_sel[SEL_BAMB]     = 1'b1; exp_len = LEN_8;  end
         IDX_CSR:      begin reg_sel[SEL_CSR]      = 1'b1; exp_len = LEN_16; end
         IDX_WBBR:     begin reg_sel[SEL_WBBR]     = 1'b1; exp_len = LEN_64; end
         IDX_PC:       begin reg_sel[SEL_PC]       = 1'b1; exp_len = LEN_64; end
         IDX_PCFIFO:   begin reg_sel[SEL_PCFIFO]   = 1'b1; exp_len = LEN_64; end
         IDX_PIPEFIFO: begin reg_sel[SEL_PIPEFIFO] = 1'b1; exp_len = LEN_64; end
         IDX_BABA:     begin reg_sel[SEL_BABA]     = 1'b1; exp_len = LEN_64; end
         IDX_BABB:     begin reg_sel[SEL_BABB]     = 1'b1; exp_len = LEN_64; end
         IDX_DADDR:    begin reg_sel[SEL_DADDR]    = 1'b1; exp_len = LEN_64; end
         IDX_DDATA:    begin reg_sel[SEL_DDATA]    = 1'b1; exp_len = LEN_64; end
         IDX_DBGFIFO:  begin reg_sel[SEL_DBGFIFO]  = 1'b1; exp_len = LEN_64; end
         IDX_DBGFIFO2: begin reg_sel[SEL_DBGFIFO2] = 1'b1; exp_len = LEN_64; end
         default:      begin reg_sel = '0;                 exp_len = LEN_32; end
      endcase
   end

endmodule

// File: rtl/ct_had_tap_seq.sv
// HAD JTAG TAP sequencer: 1149.1 state machine, shifter strobes, IR latch
// and register select decode. Define HAD_TAP_SHIFT_CHK_EN for DR length checking.
//
// state  | meaning
// TLR  F | test-logic-reset, IR forced to reset value
// RTI  C | run-test/idle
// SEL_DR 7 / SEL_IR 4 | scan select, branch DR or IR
// CAP_DR 6 | shifter captures register contents
// SH_DR 2 / SH_IR A | one shifter bit per cycle
// EX1 1/9, PAU 3/B, EX2 0/8 | exit / pause (data held) / exit2
// UPD_DR 5 | register bank writes/reads, one-cycle pulse
// UPD_IR D | IR latched from shifter on the edge leaving this state
module ct_had_tap_seq
   import ct_had_tap_pkg::*;
#(
   parameter int              IR_W   = 8,
   parameter logic [IR_W-1:0] IR_RST = IR_RST_VAL
) (
   input  logic        tclk,
   input  logic        trst,
   input  logic        io_sm_tms,
   input  logic [15:0] serial_xx_data,
   output logic        sm_serial_shift_ir,
   output logic        sm_serial_capture_dr,
   output logic        sm_serial_shift_dr,
   output logic        sm_xx_write_en,
   output logic        sm_xx_update_dr,
   output logic        sm_xx_update_ir,
   output logic        ir_xx_otc_reg_sel,
   output logic        ir_xx_mbca_reg_sel,
   output logic        ir_xx_mbcb_reg_sel,
   output logic        ir_xx_bama_reg_sel,
   output logic        ir_xx_bamb_reg_sel,
   output logic        ir_xx_csr_reg_sel,
   output logic        ir_xx_wbbr_reg_sel,
   output logic        ir_xx_pc_reg_sel,
   output logic        ir_xx_pcfifo_reg_sel,
   output logic        ir_xx_pipefifo_reg_sel,
   output logic        ir_xx_baba_reg_sel,
   output logic        ir_xx_babb_reg_sel,
   output logic        ir_xx_daddr_reg_sel,
   output logic        ir_xx_ddata_reg_sel,
   output logic        ir_xx_dbgfifo_reg_sel,
   output logic        ir_xx_dbgfifo2_reg_sel,
   output logic [3:0]  sm_tap_state,
   output logic        sm_len_err
);

   tap_state_e         state_q, state_d;
   logic [IR_W-1:0]    ir_q, ir_d;
   logic [NUM_SEL-1:0] reg_sel;
   logic [6:0]         exp_len;

   always_ff @(posedge tclk) begin
      if (trst) begin
         state_q <= TAP_TLR;
         ir_q    <= IR_RST;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         TAP_TLR:    state_d = io_sm_tms ? TAP_TLR    : TAP_RTI;
         TAP_RTI:    state_d = io_sm_tms ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_DR: state_d = io_sm_tms ? TAP_SEL_IR : TAP_CAP_DR;
         TAP_CAP_DR: state_d = io_sm_tms ? TAP_EX1_DR : TAP_SH_DR;
         TAP_SH_DR:  state_d = io_sm_tms ? TAP_EX1_DR : TAP_SH_DR;
         TAP_EX1_DR: state_d = io_sm_tms ? TAP_UPD_DR : TAP_PAU_DR;
         TAP_PAU_DR: state_d = io_sm_tms ? TAP_EX2_DR : TAP_PAU_DR;
         TAP_EX2_DR: state_d = io_sm_tms ? TAP_UPD_DR : TAP_SH_DR;
         TAP_UPD_DR: state_d = io_sm_tms ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_IR: state_d = io_sm_tms ? TAP_TLR    : TAP_CAP_IR;
         TAP_CAP_IR: state_d = io_sm_tms ? TAP_EX1_IR : TAP_SH_IR;
         TAP_SH_IR:  state_d = io_sm_tms ? TAP_EX1_IR : TAP_SH_IR;
         TAP_EX1_IR: state_d = io_sm_tms ? TAP_UPD_IR : TAP_PAU_IR;
         TAP_PAU_IR: state_d = io_sm_tms ? TAP_EX2_IR : TAP_PAU_IR;
         TAP_EX2_IR: state_d = io_sm_tms ? TAP_UPD_IR : TAP_SH_IR;
         TAP_UPD_IR: state_d = io_sm_tms ? TAP_SEL_DR : TAP_RTI;
         default:    state_d = TAP_TLR;
      endcase

      // UPD_IR never leads to TLR, so the two IR writes cannot collide
      ir_d = ir_q;
      if (state_q == TAP_UPD_IR) ir_d = serial_xx_data[IR_W-1:0];
      if (state_d == TAP_TLR)    ir_d = IR_RST;
   end

   assign sm_serial_shift_ir   = (state_q == TAP_SH_IR);
   assign sm_serial_capture_dr = (state_q == TAP_CAP_DR);
   assign sm_serial_shift_dr   = (state_q == TAP_SH_DR);
   assign sm_xx_update_dr      = (state_q == TAP_UPD_DR);
   assign sm_xx_update_ir      = (state_q == TAP_UPD_IR);
   assign sm_xx_write_en       = ~ir_q[IR_W-1];
   assign sm_tap_state         = state_q;

   ct_had_ir_decode u_ir_decode (
      .ir_idx  (ir_q[4:0]),
      .reg_sel (reg_sel),
      .exp_len (exp_len)
   );

   assign ir_xx_otc_reg_sel      = reg_sel[SEL_OTC];
   assign ir_xx_mbca_reg_sel     = reg_sel[SEL_MBCA];
   assign ir_xx_mbcb_reg_sel     = reg_sel[SEL_MBCB];
   assign ir_xx_bama_reg_sel     = reg_sel[SEL_BAMA];
   assign ir_xx_bamb_reg_sel     = reg_sel[SEL_BAMB];
   assign ir_xx_csr_reg_sel      = reg_sel[SEL_CSR];
   assign ir_xx_wbbr_reg_sel     = reg_sel[SEL_WBBR];
   assign ir_xx_pc_reg_sel       = reg_sel[SEL_PC];
   assign ir_xx_pcfifo_reg_sel   = reg_sel[SEL_PCFIFO];
   assign ir_xx_pipefifo_reg_sel = reg_sel[SEL_PIPEFIFO];
   assign ir_xx_baba_reg_sel     = reg_sel[SEL_BABA];
   assign ir_xx_babb_reg_sel     = reg_sel[SEL_BABB];
   assign ir_xx_daddr_reg_sel    = reg_sel[SEL_DADDR];
   assign ir_xx_ddata_reg_sel    = reg_sel[SEL_DDATA];
   assign ir_xx_dbgfifo_reg_sel  = reg_sel[SEL_DBGFIFO];
   assign ir_xx_dbgfifo2_reg_sel = reg_sel[SEL_DBGFIFO2];

`ifdef HAD_TAP_SHIFT_CHK_EN
   logic [6:0] shift_cnt_q, shift_cnt_d;

   always_ff @(posedge tclk) begin
      if (trst) shift_cnt_q <= '0;
      else      shift_cnt_q <= shift_cnt_d;
   end

   always_comb begin
      shift_cnt_d = shift_cnt_q;
      if (state_q == TAP_CAP_DR)
         shift_cnt_d = '0;
      else if (state_q == TAP_SH_DR && shift_cnt_q != SHIFT_CNT_MAX)
         shift_cnt_d = shift_cnt_q + 7'd1;
   end

   assign sm_len_err = (state_q == TAP_UPD_DR) && (shift_cnt_q != exp_len);

   logic unused_ok;
   assign unused_ok = ^{serial_xx_data[15:IR_W], ir_q[IR_W-2:5]};
`else
   assign sm_len_err = 1'b0;

   logic unused_ok;
   assign unused_ok = ^{serial_xx_data[15:IR_W], ir_q[IR_W-2:5], exp_len};
`endif

endmodule

// File: tb/tb_ct_had_tap_seq.sv
// Scoreboard bench for ct_had_tap_seq: a reference TAP model pushes the
// expected outputs per driven cycle; the DUT response is popped and compared.
module tb_ct_had_tap_seq;

   logic        tclk = 1'b0;
   logic        trst = 1'b1;
   logic        io_sm_tms = 1'b1;
   logic [15:0] serial_xx_data = 16'h0000;

   logic sm_serial_shift_ir, sm_serial_capture_dr, sm_serial_shift_dr;
   logic sm_xx_write_en, sm_xx_update_dr, sm_xx_update_ir, sm_len_err;
   logic [3:0] sm_tap_state;
   logic otc, mbca, mbcb, bama, bamb, csr, wbbr, pc, pcfifo, pipefifo;
   logic baba, babb, daddr, ddata, dbgfifo, dbgfifo2;

`ifdef HAD_TAP_SHIFT_CHK_EN
   localparam int CHK_EN = 1;
`else
   localparam int CHK_EN = 0;
`endif

   ct_had_tap_seq dut (
      .tclk                   (tclk),
      .trst                   (trst),
      .io_sm_tms              (io_sm_tms),
      .serial_xx_data         (serial_xx_data),
      .sm_serial_shift_ir     (sm_serial_shift_ir),
      .sm_serial_capture_dr   (sm_serial_capture_dr),
      .sm_serial_shift_dr     (sm_serial_shift_dr),
      .sm_xx_write_en         (sm_xx_write_en),
      .sm_xx_update_dr        (sm_xx_update_dr),
      .sm_xx_update_ir        (sm_xx_update_ir),
      .ir_xx_otc_reg_sel      (otc),
      .ir_xx_mbca_reg_sel     (mbca),
      .ir_xx_mbcb_reg_sel     (mbcb),
      .ir_xx_bama_reg_sel     (bama),
      .ir_xx_bamb_reg_sel     (bamb),
      .ir_xx_csr_reg_sel      (csr),
      .ir_xx_wbbr_reg_sel     (wbbr),
      .ir_xx_pc_reg_sel       (pc),
      .ir_xx_pcfifo_reg_sel   (pcfifo),
      .ir_xx_pipefifo_reg_sel (pipefifo),
      .ir_xx_baba_reg_sel     (baba),
      .ir_xx_babb_reg_sel     (babb),
      .ir_xx_daddr_reg_sel    (daddr),
      .ir_xx_ddata_reg_sel    (ddata),
      .ir_xx_dbgfifo_reg_sel  (dbgfifo),
      .ir_xx_dbgfifo2_reg_sel (dbgfifo2),
      .sm_tap_state           (sm_tap_state),
      .sm_len_err             (sm_len_err)
   );

   always #5 tclk = ~tclk;

   logic [3:0]  m_st;
   logic [7:0]  m_ir;
   int          m_cnt;
   logic [26:0] sb_q[$];
   int n_chk = 0, n_pass = 0;
   int t_cap = 0, t_shdr = 0, t_shir = 0, t_upd_dr = 0, t_upd_ir = 0, t_len = 0;

   function automatic logic [3:0] nxt(input logic [3:0] s, input logic t);
      case (s)
         4'hF: return t ? 4'hF : 4'hC;
         4'hC: return t ? 4'h7 : 4'hC;
         4'h7: return t ? 4'h4 : 4'h6;
         4'h4: return t ? 4'hF : 4'hE;
         4'h6: return t ? 4'h1 : 4'h2;
         4'h2: return t ? 4'h1 : 4'h2;
         4'h1: return t ? 4'h5 : 4'h3;
         4'h3: return t ? 4'h0 : 4'h3;
         4'h0: return t ? 4'h5 : 4'h2;
         4'h5: return t ? 4'h7 : 4'hC;
         4'hE: return t ? 4'h9 : 4'hA;
         4'hA: return t ? 4'h9 : 4'hA;
         4'h9: return t ? 4'hD : 4'hB;
         4'hB: return t ? 4'h8 : 4'hB;
         4'h8: return t ? 4'hD : 4'hA;
         default: return t ? 4'h7 : 4'hC;
      endcase
   endfunction

   // bit 15 = otc ... bit 0 = dbgfifo2
   function automatic logic [15:0] sel_of(input logic [4:0] i);
      case (i)
         5'h01: return 16'h8000;  5'h02: return 16'h4000;
         5'h03: return 16'h2000;  5'h04: return 16'h1000;
         5'h05: return 16'h0800;  5'h06: return 16'h0400;
         5'h08: return 16'h0200;  5'h09: return 16'h0100;
         5'h0A: return 16'h0080;  5'h0B: return 16'h0040;
         5'h0C: return 16'h0020;  5'h0D: return 16'h0010;
         5'h0E: return 16'h0008;  5'h0F: return 16'h0004;
         5'h10: return 16'h0002;  5'h11: return 16'h0001;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic int len_of(input logic [4:0] i);
      if (i >= 5'h01 && i <= 5'h05) return 8;
      if (i == 5'h06) return 16;
      if (i >= 5'h08 && i <= 5'h11) return 64;
      return 32;
   endfunction

   function automatic logic [15:0] dut_sels();
      return {otc, mbca, mbcb, bama, bamb, csr, wbbr, pc, pcfifo, pipefifo,
              baba, babb, daddr, ddata, dbgfifo, dbgfifo2};
   endfunction

   function automatic logic [26:0] dut_out();
      return {sm_tap_state, sm_serial_shift_ir, sm_serial_capture_dr, sm_serial_shift_dr,
              sm_xx_write_en, sm_xx_update_dr, sm_xx_update_ir, sm_len_err, dut_sels()};
   endfunction

   function automatic logic [26:0] model_out();
      logic le;
      le = (CHK_EN != 0) && (m_st == 4'h5) && (m_cnt != len_of(m_ir[4:0]));
      return {m_st, m_st == 4'hA, m_st == 4'h6, m_st == 4'h2, ~m_ir[7],
              m_st == 4'h5, m_st == 4'hD, le, sel_of(m_ir[4:0])};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step(input logic t, input logic r);
      logic [3:0]  n;
      logic [26:0] o, e;
      @(negedge tclk);
      io_sm_tms = t;
      trst      = r;
      if (r) begin
         m_st = 4'hF; m_ir = 8'hFF; m_cnt = 0;
      end else begin
         n = nxt(m_st, t);
         if (m_st == 4'hD) m_ir = serial_xx_data[7:0];
         if (m_st == 4'h6) m_cnt = 0;
         else if (m_st == 4'h2 && m_cnt < 127) m_cnt++;
         if (n == 4'hF) m_ir = 8'hFF;
         m_st = n;
      end
      sb_q.push_back(model_out());
      @(posedge tclk);
      #1;
      o = dut_out();
      e = sb_q.pop_front();
      chk("cycle", {5'd0, o}, {5'd0, e});
      t_shir   += int'(o[22]);
      t_cap    += int'(o[21]);
      t_shdr   += int'(o[20]);
      t_upd_dr += int'(o[18]);
      t_upd_ir += int'(o[17]);
      t_len    += int'(o[16]);
   endtask

   // From RTI: shift 8 IR bits, update, return to RTI (IR valid after return)
   task automatic load_ir(input logic [7:0] v);
      serial_xx_data = {8'h00, v};
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      repeat (7) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic dr_xfer(input int nsh, input int npause);
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      repeat (nsh - 1) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      if (npause > 0) begin
         repeat (npause) step(1'b0, 1'b0);
         step(1'b1, 1'b0);
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   initial begin
      int b_cap, b_shdr, b_shir, b_upd_dr, b_upd_ir, b_len;
      logic t, r;

      step(1'b1, 1'b1);
      chk("rst_state", sm_tap_state, 4'hF);
      chk("rst_we", sm_xx_write_en, 1'b0);
      chk("rst_sels", dut_sels(), 16'h0);
      step(1'b0, 1'b0);
      chk("rti_state", sm_tap_state, 4'hC);

      b_upd_ir = t_upd_ir; b_shir = t_shir;
      load_ir(8'h0E);
      chk("ir_upd_pulses", t_upd_ir - b_upd_ir, 1);
      chk("ir_shift_cycles", t_shir - b_shir, 8);
      chk("daddr_sel", daddr, 1'b1);
      chk("we_0e", sm_xx_write_en, 1'b1);

      load_ir(8'h86);
      chk("csr_sel", csr, 1'b1);
      b_cap = t_cap; b_shdr = t_shdr; b_upd_dr = t_upd_dr; b_len = t_len;
      dr_xfer(16, 0);
      chk("dr16_cap", t_cap - b_cap, 1);
      chk("dr16_shift", t_shdr - b_shdr, 16);
      chk("dr16_upd", t_upd_dr - b_upd_dr, 1);
      chk("dr16_len_err", t_len - b_len, 0);
      chk("dr16_we", sm_xx_write_en, 1'b0);

      b_cap = t_cap; b_shdr = t_shdr; b_upd_dr = t_upd_dr; b_len = t_len;
      dr_xfer(15, 3);
      chk("dr15_cap", t_cap - b_cap, 1);
      chk("dr15_shift", t_shdr - b_shdr, 15);
      chk("dr15_upd", t_upd_dr - b_upd_dr, 1);
      chk("dr15_len_err", t_len - b_len, CHK_EN);

      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b0);
      chk("tms5_state", sm_tap_state, 4'hF);
      chk("tms5_we", sm_xx_write_en, 1'b0);
      chk("tms5_sels", dut_sels(), 16'h0);
      step(1'b0, 1'b0);

      load_ir(8'h0E);
      serial_xx_data = 16'h0001;
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      step(1'b0, 1'b0); step(1'b0, 1'b0);
      b_upd_ir = t_upd_ir;
      step(1'b1, 1'b1);
      chk("trst_state", sm_tap_state, 4'hF);
      chk("trst_we", sm_xx_write_en, 1'b0);
      chk("trst_sels", dut_sels(), 16'h0);
      step(1'b0, 1'b0); step(1'b0, 1'b0);
      chk("trst_no_upd_ir", t_upd_ir - b_upd_ir, 0);

      // random TMS walk with occasional reset, all checked by the scoreboard
      for (int i = 0; i < 400; i++) begin
         serial_xx_data = 16'($urandom_range(0, 65535));
         if (i % 40 < 3) serial_xx_data[4:0] = 5'($urandom_range(0, 17));
         t = ($urandom_range(0, 99) < 35);
         r = ($urandom_range(0, 99) == 0);
         step(t, r);
      end

      chk("sb_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
